// File: rtl/crc_sched_pkg.sv
// Shared types for the CRC engine scheduler: FSM states, tag-pipeline entry, stats width.
package crc_sched_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HALT} crc_sched_state_t;

    // Sized for the largest supported requester count (16)
    localparam int TAG_ID_W = 4;
    localparam int STATS_W  = 16;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } crc_tag_t;

endpackage

// File: rtl/crc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module crc_rr_arbiter #(
    parameter int p_num_req = 4,
    parameter int IDW       = $clog2(p_num_req)
) (
    input  logic [p_num_req-1:0] req,
    input  logic [IDW-1:0]       ptr,
    output logic [p_num_req-1:0] gnt,
    output logic [IDW-1:0]       idx
);

    int j;

    // Walk from lowest priority to highest so the last hit is the winner
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = p_num_req - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % p_num_req;
            if (req[j]) begin
                gnt = p_num_req'(1) << j;
                idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/crc_sched.sv
// Round-robin scheduler sharing one pipelined CRC engine; owner tags ride alongside the engine.
// Optional per-requester grant counters under `CRC_SCHED_STATS_EN.
module crc_sched
    import crc_sched_pkg::*;
#(
    parameter int p_num_req = 4,
    parameter int p_width   = 8,
    parameter int p_latency = 32
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [p_num_req-1:0]           req_valid,
    input  logic [p_num_req*p_width-1:0]   req_data,
    output logic [p_num_req-1:0]           req_ready,
    output logic                           eng_valid,
    output logic [p_width-1:0]             eng_data,
    input  logic [p_width-1:0]             eng_result,
    output logic                           rsp_valid,
    output logic [$clog2(p_num_req)-1:0]   rsp_id,
    output logic [p_width-1:0]             rsp_data,
    input  logic                           flush,
    output logic                           flush_done,
    output logic                           busy
`ifdef CRC_SCHED_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [p_num_req*STATS_W-1:0]   grant_cnt
`endif
);

    localparam int IDW  = $clog2(p_num_req);
    localparam int CNTW = $clog2(p_latency + 3);

    crc_sched_state_t     state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    crc_tag_t             tag_q [0:p_latency];
    crc_tag_t             tag_d [0:p_latency];
    logic                 eng_valid_q, eng_valid_d;
    logic [p_width-1:0]   eng_data_q, eng_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [p_width-1:0]   rsp_data_q, rsp_data_d;
    logic                 flush_done_q, flush_done_d;
    logic                 busy_q, busy_d;

    logic [p_num_req-1:0] gnt;
    logic [IDW-1:0]       gnt_idx;
    logic                 open;
    logic                 acc;

    crc_rr_arbiter #(.p_num_req(p_num_req), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign open      = (state_q == IDLE) || (state_q == BUSY);
    assign req_ready = open ? gnt : '0;
    assign acc       = |req_ready;

    always_comb begin
        ptr_d = ptr_q;
        if (acc)
            ptr_d = (gnt_idx == IDW'(p_num_req - 1)) ? '0 : gnt_idx + IDW'(1);

        cnt_d       = cnt_q + CNTW'(acc) - CNTW'(rsp_valid_q);
        eng_valid_d = acc;
        eng_data_d  = acc ? req_data[gnt_idx*p_width +: p_width] : eng_data_q;

        tag_d[0].vld = acc;
        tag_d[0].id  = TAG_ID_W'(gnt_idx);
        for (int k = 1; k <= p_latency; k++)
            tag_d[k] = tag_q[k-1];

        // The last tag stage lines up with the engine output for the same word
        rsp_valid_d = tag_q[p_latency].vld;
        rsp_id_d    = rsp_valid_d ? IDW'(tag_q[p_latency].id) : rsp_id_q;
        rsp_data_d  = rsp_valid_d ? eng_result : rsp_data_q;

        state_d = state_q;
        case (state_q)
            IDLE, BUSY: begin
                if (flush)
                    state_d = (cnt_d == '0) ? HALT : DRAIN;
                else if (acc)
                    state_d = BUSY;
                else if (state_q == BUSY && cnt_d == '0)
                    state_d = IDLE;
            end
            DRAIN:   if (cnt_d == '0) state_d = HALT;
            HALT:    if (!flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        flush_done_d = (state_d == HALT);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            for (int k = 0; k <= p_latency; k++)
                tag_q[k] <= '0;
            eng_valid_q  <= 1'b0;
            eng_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            for (int k = 0; k <= p_latency; k++)
                tag_q[k] <= tag_d[k];
            eng_valid_q  <= eng_valid_d;
            eng_data_q   <= eng_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            flush_done_q <= flush_done_d;
            busy_q       <= busy_d;
        end
    end

    assign eng_valid  = eng_valid_q;
    assign eng_data   = eng_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign flush_done = flush_done_q;
    assign busy       = busy_q;

`ifdef CRC_SCHED_STATS_EN
    logic [p_num_req-1:0][STATS_W-1:0] gcnt_q, gcnt_d;

    // Clear wins over a coincident accept
    always_comb begin
        for (int i = 0; i < p_num_req; i++) begin
            gcnt_d[i] = gcnt_q[i];
            if (stats_clr)
                gcnt_d[i] = '0;
            else if (req_ready[i] && gcnt_q[i] != '1)
                gcnt_d[i] = gcnt_q[i] + STATS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) gcnt_q <= '0;
        else       gcnt_q <= gcnt_d;
    end

    assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_crc_sched.sv
// Scoreboard bench for crc_sched: round-robin reference model, CRC-8 engine model, queued expectations.
module tb_crc_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int L   = 32;
    localparam int LAT = L + 2;

    logic             clk = 1'b0;
    logic             rstN = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             eng_valid;
    logic [W-1:0]     eng_data;
    logic [W-1:0]     eng_result;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    logic             flush;
    logic             flush_done;
    logic             busy;
`ifdef CRC_SCHED_STATS_EN
    logic             stats_clr;
    logic [N*16-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    crc_sched #(.p_num_req(N), .p_width(W), .p_latency(L)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .eng_valid  (eng_valid),
        .eng_data   (eng_data),
        .eng_result (eng_result),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy)
`ifdef CRC_SCHED_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    function automatic logic [7:0] crc8(input logic [7:0] d);
        logic [7:0] c;
        c = d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Engine model: CRC-8 of the input word, L cycles later
    logic [W-1:0] epipe [L];
    always @(posedge clk) begin
        epipe[0] <= crc8(eng_data);
        for (int k = 1; k < L; k++) epipe[k] <= epipe[k-1];
    end
    assign eng_result = epipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t eng_q[$];
    exp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_rsp = 0;
    int   last_rsp_cyc = 0;
    bit   chk_en = 1'b0;
    bit   m_blocked = 1'b0;
    int   m_ptr = 0;
    int   g;
    logic [N-1:0] exp_rdy;
    logic [7:0]   d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbiter: first valid requester at or after the pointer, unless draining/halted
    always @(negedge clk) begin
        if (!rstN) m_ptr = 0;
        else if (chk_en) begin
            g = -1;
            if (!m_blocked)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (g >= 0) begin
                d = req_data[g*W +: W];
                eng_q.push_back('{g, d, cyc + 1});
                rsp_q.push_back('{g, crc8(d), cyc + LAT});
                m_ptr = (g + 1) % N;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT presents a word or a response
    exp_t e;
    always @(negedge clk) begin
        if (eng_valid) begin
            if (eng_q.size() == 0) chk("eng_unexpected", 32'(eng_data), 32'hFFFF_FFFF);
            else begin
                e = eng_q.pop_front();
                chk("eng_data", 32'(eng_data), 32'(e.data));
                chk("eng_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (eng_q.size() > 0 && eng_q[0].cyc <= cyc) begin
            e = eng_q.pop_front();
            chk("eng_missing", 32'(eng_valid), 32'd1);
        end
        if (rsp_valid) begin
            n_rsp++;
            last_rsp_cyc = cyc;
            if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
            else begin
                e = rsp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
            e = rsp_q.pop_front();
            chk("rsp_missing", 32'(rsp_valid), 32'd1);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_eng_valid"}, 32'(eng_valid), 32'd0);
        chk({tag, "_eng_data"}, 32'(eng_data), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_flush_done"}, 32'(flush_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 60 && (rsp_q.size() != 0 || eng_q.size() != 0); i++) cycle();
        chk("drain_timeout", 32'(rsp_q.size()), 32'd0);
    endtask

    int n0;
    bit seen;

    initial begin
        req_valid = '0;
        req_data  = '0;
        flush     = 1'b0;
`ifdef CRC_SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        #1 rstN = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        cycle();
        rstN   = 1'b1;
        chk_en = 1'b1;

        // Single job from requester 2
        req_valid = 4'b0100;
        req_data  = {8'h11, 8'h30, 8'h22, 8'h33};
        cycle();
        req_valid = '0;
        drain_wait();
        chk("idle_busy", 32'(busy), 32'd0);

        // All requesters continuously valid
        for (int i = 0; i < 16; i++) begin
            req_valid = '1;
            req_data  = $urandom;
            cycle();
        end
        req_valid = '0;
        drain_wait();

        // Pointer wrap: last grant 3, then 1 and 3 contend
        req_valid = 4'b1000;
        req_data  = $urandom;
        cycle();
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'b1010;
            req_data  = $urandom;
            cycle();
        end
        req_valid = '0;
        drain_wait();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            req_valid = N'($urandom);
            req_data  = $urandom;
            cycle();
        end
        req_valid = '0;
        drain_wait();

        // Flush with five words in flight; the fifth accept coincides with flush
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0001;
            req_data  = $urandom;
            if (i == 4) flush = 1'b1;
            n0 = n_rsp;
            cycle();
        end
        m_blocked = 1'b1;
        req_valid = '1;
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (flush_done) seen = 1'b1;
        end
        chk("flush_done_seen", 32'(seen), 32'd1);
        chk("flush_done_cycle", 32'(cyc), 32'(last_rsp_cyc + 1));
        chk("flush_rsp_count", 32'(n_rsp - n0), 32'd5);
        req_valid = '0;
        cycle();
        flush = 1'b0;
        cycle();
        m_blocked = 1'b0;
        @(negedge clk);
        chk("post_halt_busy", 32'(busy), 32'd0);
        chk("post_halt_done", 32'(flush_done), 32'd0);

        // Reset with ten words in flight
        for (int i = 0; i < 10; i++) begin
            req_valid = '1;
            req_data  = $urandom;
            cycle();
        end
        rstN      = 1'b0;
        req_valid = '0;
        chk_en    = 1'b0;
        eng_q.delete();
        rsp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        cycle();
        rstN   = 1'b1;
        chk_en = 1'b1;
        n0 = n_rsp;
        repeat (40) @(negedge clk);
        chk("no_rsp_after_reset", 32'(n_rsp - n0), 32'd0);

`ifdef CRC_SCHED_STATS_EN
        for (int i = 0; i < 70000; i++) begin
            req_valid = 4'b0001;
            req_data  = $urandom;
            cycle();
        end
        req_valid = '0;
        drain_wait();
        chk("grant_cnt_sat", 32'(grant_cnt[15:0]), 32'hFFFF);
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        @(negedge clk);
        chk("grant_cnt_clr", 32'(grant_cnt[15:0]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
